polyred_reader: RTL and testbench
=================================

Name: polyred_reader

Overview:
- Consumes the raw product polynomial c(x) that the inversion-path polynomial multiplier writes into product memory, i.e. it is the reader of that memory.
- Reduces c(x) modulo x^P - x - 1 and each coefficient modulo Q.
- Writes the P reduced 13-bit coefficients into a result memory and reports the result degree.
- Sits between the multiplier and the next inversion step in the SNTRUP757 datapath.

Parameters:
P, 757, ring degree (x^P = x + 1)
Q, 4591, coefficient modulus
AW, 11, product memory address width (must cover 2P-2)
DW, 26, product coefficient width (unsigned)
CW, 13, result coefficient width
RW, 10, result memory address width (must cover P-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin reduction; sampled only in IDLE
deg_in  input  AW  degree of product polynomial c(x), valid when start sampled
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when all P coefficients are written
deg_out  output  AW  result degree: deg_in if deg_in < P, else P-1; held until next start
mem_address_r  output  AW  product memory read address
mem_output_r  input  DW  product memory read data, synchronous, 1-cycle latency
mem_address_w  output  RW  result memory write address
mem_input_w  output  CW  result coefficient
write_enable  output  1  result memory write strobe

Behaviour:
- Math:
  - Since deg c <= 2P-2, r[k] = c[k] + c[k+P] + c[k+P-1] mod Q, for k = 0..P-1.
  - The c[k+P-1] term is forced to 0 when k = 0.
  - Any term whose index exceeds deg_in is forced to 0 regardless of memory contents.
  - Addresses above deg_in are still issued; only the data is masked.
- Arithmetic:
  - Terms are unsigned DW bits; the sum is held at DW+2 = 28 bits with no overflow.
  - The reduction sum mod Q yields a result in [0, Q-1] and is registered into mem_input_w in the WRITE state.
- Reset: async on rst_n low. FSM = IDLE, k = 0, busy = 0, done = 0, write_enable = 0, all address/data outputs = 0, deg_out = 0.
- FSM states: IDLE, ADDR0, ADDR1, ADDR2, CAP2, WRITE, FIN.
- IDLE:
  - On start = 1: latch deg_in, compute deg_out, set k = 0, go to ADDR0.
  - Otherwise stay in IDLE.
- ADDR0: mem_address_r = k.
- ADDR1: mem_address_r = k+P-1; capture term0.
- ADDR2: mem_address_r = k+P; capture term1.
- CAP2: capture term2; form the sum.
- WRITE:
  - write_enable = 1 for exactly this cycle; mem_address_w = k; mem_input_w = sum mod Q.
  - If k = P-1, go to FIN; else k++ and go to ADDR0.
- FIN: done = 1 for one cycle; go to IDLE.
- Timing:
  - Each coefficient takes exactly 5 cycles.
  - done asserts 5P+1 cycles after the start-sampling edge (3786 for P = 757).
  - Writes occur in strictly ascending address order, exactly once per address.
- busy is 1 in every state except IDLE.
- start while busy: ignored, no effect on the current run.
- Reset mid-operation: write_enable drops immediately (asynchronous); no partial write completes; the next start performs a full run.
- The product memory is never written by this block; the result memory is never read.

Test Plan:
- c[0] = 1, all else 0, deg_in = 0 -> r[0] = 1, r[1..756] = 0, deg_out = 0, done at cycle 3786, exactly 757 write strobes.
- c[757] = 1, deg_in = 757 -> r[0] = 1, r[1] = 1, rest 0, deg_out = 756.
- c[1512] = 5, deg_in = 1512 -> r[755] = 5, r[756] = 5, rest 0.
- All c[0..1512] = 2^26-1, deg_in = 1512 -> r[0] = 4432, r[1..755] = 2057, r[756] = 4432.
- deg_in = 10, c[0..10] = 1, memory above 10 filled with 0x3FFFFFF -> r[0..10] = 1, rest 0, deg_out = 10.
- Start pulsed again at k = 50 -> ignored, run unchanged. rst_n low at k = 100 -> write_enable, busy and done go low immediately. A new start afterwards -> a complete correct run.

Source files
------------

// File: rtl/polyred_if.sv
// Handshake, product-memory read port and result-memory write port of the
// polynomial reducer, bundled for connection between reducer and memories.
interface polyred_if #(
  parameter int AW = 11,
  parameter int DW = 26,
  parameter int CW = 13,
  parameter int RW = 10
);
  logic          start;
  logic [AW-1:0] deg_in;
  logic          busy;
  logic          done;
  logic [AW-1:0] deg_out;
  logic [AW-1:0] mem_address_r;
  logic [DW-1:0] mem_output_r;
  logic [RW-1:0] mem_address_w;
  logic [CW-1:0] mem_input_w;
  logic          write_enable;

  modport master (
    output start, deg_in, mem_output_r,
    input  busy, done, deg_out, mem_address_r, mem_address_w, mem_input_w, write_enable
  );

  modport slave (
    input  start, deg_in, mem_output_r,
    output busy, done, deg_out, mem_address_r, mem_address_w, mem_input_w, write_enable
  );
endinterface

// File: rtl/polyred_reader.sv
// Reduces the raw product c(x) modulo x^P - x - 1 and each coefficient modulo Q,
// reading three product terms per output coefficient and writing P results in order.
module polyred_reader #(
  parameter int P  = 757,
  parameter int Q  = 4591,
  parameter int AW = 11,
  parameter int DW = 26,
  parameter int CW = 13,
  parameter int RW = 10
) (
  input logic      clk,
  input logic      rst_n,
  polyred_if.slave bus
);
  localparam int SW = DW + 2;

  typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, ADDR2, CAP2, WRITE, FIN} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] k;
  logic [AW-1:0] deg;
  logic [DW-1:0] term0_p0;
  logic [DW-1:0] term1_p1;
  logic [AW-1:0] idx_k, idx_lo, idx_hi;
  logic          last_k;

  assign idx_k  = AW'(k);
  assign idx_lo = AW'(k) + AW'(P - 1);
  assign idx_hi = AW'(k) + AW'(P);
  assign last_k = (k == RW'(P - 1));

  function automatic logic [DW-1:0] mask_term(input logic [DW-1:0] d,
                                              input logic [AW-1:0] idx,
                                              input logic [AW-1:0] limit,
                                              input logic          en);
    return (en && (idx <= limit)) ? d : '0;
  endfunction

  function automatic logic [CW-1:0] reduce_mod(input logic [SW-1:0] s);
    return CW'(s % SW'(Q));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ADDR0;
      ADDR0:   state_nxt = ADDR1;
      ADDR1:   state_nxt = ADDR2;
      ADDR2:   state_nxt = CAP2;
      CAP2:    state_nxt = WRITE;
      WRITE:   state_nxt = last_k ? FIN : ADDR0;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and addresses decode straight from state so reset removes them at once
  always_comb begin
    bus.busy          = (state != IDLE);
    bus.done          = (state == FIN);
    bus.write_enable  = (state == WRITE);
    bus.mem_address_w = (state == WRITE) ? k : '0;
    case (state)
      ADDR0:   bus.mem_address_r = idx_k;
      ADDR1:   bus.mem_address_r = idx_lo;
      ADDR2:   bus.mem_address_r = idx_hi;
      default: bus.mem_address_r = '0;
    endcase
  end

  // p0: c[k], p1: c[k+P-1], p2: c[k+P] summed and reduced into the write register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k               <= '0;
      deg             <= '0;
      bus.deg_out     <= '0;
      term0_p0        <= '0;
      term1_p1        <= '0;
      bus.mem_input_w <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          k           <= '0;
          deg         <= bus.deg_in;
          bus.deg_out <= (bus.deg_in < AW'(P)) ? bus.deg_in : AW'(P - 1);
        end
        ADDR1: term0_p0 <= mask_term(bus.mem_output_r, idx_k, deg, 1'b1);
        ADDR2: term1_p1 <= mask_term(bus.mem_output_r, idx_lo, deg, (k != '0));
        CAP2:  bus.mem_input_w <= reduce_mod(SW'(term0_p0) + SW'(term1_p1) +
                                   SW'(mask_term(bus.mem_output_r, idx_hi, deg, 1'b1)));
        WRITE: if (!last_k) k <= k + RW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_polyred_reader.sv
// Directed bench for polyred_reader: product memory model, result capture,
// a folding reference model and per-write checking against it.
module tb_polyred_reader;
  localparam int P  = 757;
  localparam int Q  = 4591;
  localparam int AW = 11;
  localparam int DW = 26;
  localparam int CW = 13;
  localparam int RW = 10;
  localparam logic [CW-1:0] SENT = 13'h1FFF;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  polyred_if #(.AW(AW), .DW(DW), .CW(CW), .RW(RW)) bus ();

  polyred_reader #(.P(P), .Q(Q), .AW(AW), .DW(DW), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [DW-1:0] prod [0:2047];
  logic [CW-1:0] res  [0:1023];
  int            model [0:P-1];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            wr_count = 0;

  always @(posedge clk) bus.mem_output_r <= prod[bus.mem_address_r];
  always @(posedge clk) if (bus.write_enable) res[bus.mem_address_w] <= bus.mem_input_w;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: fold every x^i (i >= P) into x^(i-P+1) + x^(i-P), then reduce mod Q
  task automatic build_model(input int deg);
    longint acc [0:2*P-2];
    for (int i = 0; i <= 2*P-2; i++) acc[i] = (i <= deg) ? longint'(prod[i]) : 0;
    for (int i = 2*P-2; i >= P; i--) begin
      acc[i-P+1] += acc[i];
      acc[i-P]   += acc[i];
      acc[i] = 0;
    end
    for (int i = 0; i < P; i++) model[i] = int'(acc[i] % Q);
  endtask

  always @(negedge clk) begin
    if (bus.write_enable) begin
      chk("wr_order", longint'(bus.mem_address_w), longint'(wr_count));
      chk("wr_data", longint'(bus.mem_input_w), longint'(model[bus.mem_address_w]));
      wr_count++;
    end
  end

  task automatic clear_prod(input logic [DW-1:0] v);
    for (int i = 0; i < 2048; i++) prod[i] = v;
  endtask

  task automatic run(input int deg, input int poke_k, input int abort_k, output int cyc);
    bit aborted = 0;
    build_model(deg);
    for (int i = 0; i < 1024; i++) res[i] = SENT;
    wr_count = 0;
    @(negedge clk);
    bus.deg_in = AW'(deg);
    bus.start  = 1;
    @(negedge clk);
    bus.start = 0;
    cyc = 1;
    while (!bus.done && cyc < 5000) begin
      bus.start = 0;
      if (poke_k >= 0 && bus.write_enable && bus.mem_address_w == RW'(poke_k)) begin
        bus.start  = 1;
        bus.deg_in = '0;
      end
      if (abort_k >= 0 && bus.write_enable && bus.mem_address_w == RW'(abort_k)) begin
        rst_n = 0;
        #1;
        chk("abort_we", longint'(bus.write_enable), 0);
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_done", longint'(bus.done), 0);
        aborted = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 0;
    if (aborted) begin
      repeat (3) @(negedge clk);
      chk("abort_nowrite", longint'(res[abort_k]), longint'(SENT));
      chk("abort_prev", longint'(res[abort_k-1]), longint'(model[abort_k-1]));
      rst_n = 1;
      @(negedge clk);
    end else begin
      chk("done_seen", longint'(bus.done), 1);
      chk("latency", longint'(cyc), 3786);
      chk("wr_strobes", longint'(wr_count), 757);
      @(negedge clk);
      chk("done_pulse", longint'(bus.done), 0);
      chk("busy_idle", longint'(bus.busy), 0);
      begin
        int bad = 0;
        for (int i = 0; i < P; i++) if (res[i] != CW'(model[i])) bad++;
        chk("res_vs_model", longint'(bad), 0);
      end
    end
  endtask

  initial begin
    int cyc;
    bus.start  = 0;
    bus.deg_in = '0;
    clear_prod('0);
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_we", longint'(bus.write_enable), 0);
    chk("rst_deg_out", longint'(bus.deg_out), 0);
    chk("rst_addr_r", longint'(bus.mem_address_r), 0);
    chk("rst_addr_w", longint'(bus.mem_address_w), 0);
    chk("rst_data_w", longint'(bus.mem_input_w), 0);
    rst_n = 1;
    @(negedge clk);

    clear_prod('0);
    prod[0] = 1;
    run(0, -1, -1, cyc);
    chk("t1_r0", longint'(res[0]), 1);
    chk("t1_r1", longint'(res[1]), 0);
    chk("t1_r756", longint'(res[756]), 0);
    chk("t1_deg_out", longint'(bus.deg_out), 0);

    clear_prod('0);
    prod[757] = 1;
    run(757, -1, -1, cyc);
    chk("t2_r0", longint'(res[0]), 1);
    chk("t2_r1", longint'(res[1]), 1);
    chk("t2_r2", longint'(res[2]), 0);
    chk("t2_deg_out", longint'(bus.deg_out), 756);

    clear_prod('0);
    prod[1512] = 5;
    run(1512, -1, -1, cyc);
    chk("t3_r755", longint'(res[755]), 5);
    chk("t3_r756", longint'(res[756]), 5);
    chk("t3_r0", longint'(res[0]), 0);
    chk("t3_deg_out", longint'(bus.deg_out), 756);

    clear_prod(26'h3FFFFFF);
    run(1512, -1, -1, cyc);
    chk("t4_r0", longint'(res[0]), 4432);
    chk("t4_r1", longint'(res[1]), 2057);
    chk("t4_r755", longint'(res[755]), 2057);
    chk("t4_r756", longint'(res[756]), 4432);
    chk("t4_model_r0", longint'(model[0]), 4432);
    chk("t4_model_r1", longint'(model[1]), 2057);

    clear_prod(26'h3FFFFFF);
    for (int i = 0; i <= 10; i++) prod[i] = 1;
    run(10, -1, -1, cyc);
    chk("t5_r0", longint'(res[0]), 1);
    chk("t5_r10", longint'(res[10]), 1);
    chk("t5_r11", longint'(res[11]), 0);
    chk("t5_r756", longint'(res[756]), 0);
    chk("t5_deg_out", longint'(bus.deg_out), 10);

    clear_prod('0);
    prod[757] = 1;
    prod[3]   = 7;
    run(757, 50, -1, cyc);
    chk("t6_r0", longint'(res[0]), 1);
    chk("t6_r1", longint'(res[1]), 1);
    chk("t6_r3", longint'(res[3]), 7);
    chk("t6_deg_out", longint'(bus.deg_out), 756);

    clear_prod(26'h3FFFFFF);
    run(1512, -1, 100, cyc);
    chk("t7_deg_out_rst", longint'(bus.deg_out), 0);

    clear_prod('0);
    prod[1512] = 5;
    run(1512, -1, -1, cyc);
    chk("t8_r755", longint'(res[755]), 5);
    chk("t8_r756", longint'(res[756]), 5);
    chk("t8_r100", longint'(res[100]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
